// File: rtl/dot_engine_sequencer.sv
// -----------------------------------------------------------------------------
// dot_engine_sequencer
//   Front-end controller for a LANES-wide, BYTE_W-bit dot-product engine.
//   A command starts a job. The controller streams weight bytes (unless held
//   weights are reused) and then data bytes into the engine's shift registers.
//   It waits out the engine result latency, captures the sum, and returns it
//   as two tagged half-words: low half first, then high half with flag set.
//
// Ports
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   cmd_valid/ready    start request; cmd_reuse_w asks to skip weight load
//   in_valid/ready     operand byte stream (in_byte)
//   eng_byte/sel/shift registered byte, register select (1=weight), strobe
//   eng_result         engine dot-product result
//   out_valid/ready    result word stream (out_word = {hi_flag, half})
//   busy               controller is not idle
// -----------------------------------------------------------------------------
module dot_engine_sequencer #(
  parameter int LANES   = 4,
  parameter int BYTE_W  = 8,
  parameter int RES_LAT = 2,
  parameter int RES_W   = 2*BYTE_W + $clog2(LANES),
  parameter int HALF_W  = RES_W/2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  input  logic              cmd_reuse_w,
  output logic              cmd_ready,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_byte,
  output logic              in_ready,
  output logic [BYTE_W-1:0] eng_byte,
  output logic              eng_sel,
  output logic              eng_shift,
  input  logic [RES_W-1:0]  eng_result,
  output logic              out_valid,
  output logic [HALF_W:0]   out_word,
  input  logic              out_ready,
  output logic              busy
);

  localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int LAT_W = $clog2(RES_LAT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_W, S_LOAD_D, S_WAIT, S_OUT_LO, S_OUT_HI
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [LAT_W-1:0]   lat;
  logic               w_loaded;
  logic [RES_W-1:0]   res_q;

  logic hs;
  logic last_byte;
  logic lat_done;

  assign hs        = in_valid & in_ready;
  assign last_byte = (cnt == CNT_W'(LANES - 1));
  // The wait counter starts at 0 in the cycle carrying the final strobe, so
  // reaching RES_LAT marks the cycle in which the engine result is valid.
  assign lat_done  = (lat == LAT_W'(RES_LAT));

  // State register and control counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      lat      <= '0;
      w_loaded <= 1'b0;
    end else begin
      state <= state_nxt;
      if (hs)
        cnt <= last_byte ? '0 : cnt + 1'b1;
      if (state == S_WAIT)
        lat <= lat + 1'b1;
      else
        lat <= '0;
      if (state == S_LOAD_W && hs && last_byte)
        w_loaded <= 1'b1;
    end
  end

  // Engine-side registered outputs; byte and select hold between strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eng_byte  <= '0;
      eng_sel   <= 1'b0;
      eng_shift <= 1'b0;
    end else begin
      eng_shift <= hs;
      if (hs) begin
        eng_byte <= in_byte;
        eng_sel  <= (state == S_LOAD_W);
      end
    end
  end

  // Result capture (pure data, no reset needed)
  always_ff @(posedge clk) begin
    if (state == S_WAIT && lat_done)
      res_q <= eng_result;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (cmd_valid)
                  state_nxt = (cmd_reuse_w && w_loaded) ? S_LOAD_D : S_LOAD_W;
      S_LOAD_W: if (hs && last_byte) state_nxt = S_LOAD_D;
      S_LOAD_D: if (hs && last_byte) state_nxt = S_WAIT;
      S_WAIT:   if (lat_done)        state_nxt = S_OUT_LO;
      S_OUT_LO: if (out_ready)       state_nxt = S_OUT_HI;
      S_OUT_HI: if (out_ready)       state_nxt = S_IDLE;
      default:                       state_nxt = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    cmd_ready = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_word  = '0;
    busy      = (state != S_IDLE);
    case (state)
      S_IDLE:   cmd_ready = 1'b1;
      S_LOAD_W,
      S_LOAD_D: in_ready  = 1'b1;
      S_OUT_LO: begin
        out_valid = 1'b1;
        out_word  = {1'b0, res_q[HALF_W-1:0]};
      end
      S_OUT_HI: begin
        out_valid = 1'b1;
        out_word  = {1'b1, res_q[RES_W-1:HALF_W]};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dot_engine_sequencer.sv
module tb_dot_engine_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_reuse_w, cmd_ready;
  logic        in_valid, in_ready;
  logic [7:0]  in_byte;
  logic [7:0]  eng_byte;
  logic        eng_sel, eng_shift;
  logic [17:0] eng_result;
  logic        out_valid, out_ready, busy;
  logic [9:0]  out_word;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  dot_engine_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_reuse_w(cmd_reuse_w), .cmd_ready(cmd_ready),
    .in_valid(in_valid), .in_byte(in_byte), .in_ready(in_ready),
    .eng_byte(eng_byte), .eng_sel(eng_sel), .eng_shift(eng_shift),
    .eng_result(eng_result),
    .out_valid(out_valid), .out_word(out_word), .out_ready(out_ready),
    .busy(busy)
  );

  // Engine model: shift-in at LSB lane, registered sum (two cycles after the strobe cycle)
  logic [7:0] ew [4];
  logic [7:0] ed [4];
  initial begin
    for (int i = 0; i < 4; i++) begin ew[i] = '0; ed[i] = '0; end
    eng_result = '0;
  end
  always @(posedge clk) begin
    logic [17:0] s;
    s = '0;
    for (int i = 0; i < 4; i++) s += 18'(ew[i]) * 18'(ed[i]);
    eng_result <= s;
    if (eng_shift) begin
      for (int i = 3; i > 0; i--) begin
        if (eng_sel) ew[i] <= ew[i-1]; else ed[i] <= ed[i-1];
      end
      if (eng_sel) ew[0] <= eng_byte; else ed[0] <= eng_byte;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Expected strobe stream {sel, byte}; every strobe must match the front entry
  logic [8:0] exp_q [$];
  always @(negedge clk) begin
    if (rst_n && eng_shift) begin
      if (exp_q.size() == 0) chk("extra_strobe", 32'd1, 32'd0);
      else chk("strobe", {23'd0, eng_sel, eng_byte}, {23'd0, exp_q.pop_front()});
    end
  end

  // Reference model state
  logic [7:0] m_w [4];
  bit         m_wloaded = 0;

  task automatic do_cmd(input bit reuse);
    int t = 0;
    while (!cmd_ready && t < 100) begin @(posedge clk); #1; t++; end
    chk("cmd_ready_before_cmd", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1; cmd_reuse_w = reuse;
    @(posedge clk); #1;
    cmd_valid = 0; cmd_reuse_w = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit sel, input bit gaps);
    int t = 0;
    if (gaps) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    while (!in_ready && t < 100) begin @(posedge clk); #1; t++; end
    if (!in_ready) begin chk("in_ready_timeout", 32'd0, 32'd1); return; end
    in_valid = 1; in_byte = b;
    exp_q.push_back({sel, b});
    @(posedge clk); #1;
    in_valid = 0; in_byte = $urandom;
  endtask

  task automatic get_result(input logic [17:0] sum, input int hold);
    int t = 0;
    logic [9:0] lo, hi;
    lo = {1'b0, sum[8:0]};
    hi = {1'b1, sum[17:9]};
    while (!out_valid && t < 100) begin @(posedge clk); #1; t++; end
    chk("out_valid_lo", {31'd0, out_valid}, 32'd1);
    chk("out_word_lo", {22'd0, out_word}, {22'd0, lo});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("lo_stable", {22'd0, out_word}, {22'd0, lo});
      chk("cmd_ready_held_low", {31'd0, cmd_ready}, 32'd0);
    end
    out_ready = 1;
    @(posedge clk); #1;
    chk("out_valid_hi", {31'd0, out_valid}, 32'd1);
    chk("out_word_hi", {22'd0, out_word}, {22'd0, hi});
    chk("cmd_ready_low_hi", {31'd0, cmd_ready}, 32'd0);
    @(posedge clk); #1;
    out_ready = 0;
    chk("cmd_ready_after_hi", {31'd0, cmd_ready}, 32'd1);
    chk("out_valid_after_hi", {31'd0, out_valid}, 32'd0);
  endtask

  // One complete job; the model decides whether weights must be reloaded
  task automatic run_op(input bit reuse, input logic [7:0] w [4], input logic [7:0] d [4],
                        input bit gaps, input int hold);
    bit load_w;
    int sum;
    load_w = !(reuse && m_wloaded);
    do_cmd(reuse);
    if (load_w) begin
      for (int i = 0; i < 4; i++) begin
        send_byte(w[i], 1'b1, gaps);
        m_w[i] = w[i];
      end
      m_wloaded = 1;
      chk("in_ready_after_w", {31'd0, in_ready}, 32'd1);
    end
    for (int i = 0; i < 4; i++) send_byte(d[i], 1'b0, gaps);
    chk("in_ready_after_d", {31'd0, in_ready}, 32'd0);
    sum = 0;
    for (int i = 0; i < 4; i++) sum += int'(m_w[i]) * int'(d[i]);
    get_result(18'(sum), hold);
    chk("strobes_consumed", exp_q.size(), 32'd0);
  endtask

  task automatic apply_reset();
    #1 rst_n = 0;
    #1;
    exp_q.delete();
    m_wloaded = 0;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_eng_shift", {31'd0, eng_shift}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  logic [7:0] w [4];
  logic [7:0] d [4];

  initial begin
    rst_n = 0; cmd_valid = 0; cmd_reuse_w = 0; in_valid = 0; in_byte = 0; out_ready = 0;
    repeat (2) @(posedge clk);
    apply_reset();
    chk("rst_out_word", {22'd0, out_word}, 32'd0);
    chk("rst_eng_sel", {31'd0, eng_sel}, 32'd0);

    // Normal: sum 70 -> 0x046 / 0x200
    w = '{8'd1, 8'd2, 8'd3, 8'd4}; d = '{8'd5, 8'd6, 8'd7, 8'd8};
    run_op(0, w, d, 0, 0);
    chk("normal_model_sum", 32'd70, 32'(1*5 + 2*6 + 3*7 + 4*8));

    // Reuse: data only, weights 1..4 held -> sum 10
    d = '{8'd1, 8'd1, 8'd1, 8'd1};
    run_op(1, w, d, 0, 0);

    // Max operands: 260100 -> 0x004 / 0x3FC
    w = '{8'hFF, 8'hFF, 8'hFF, 8'hFF}; d = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    run_op(0, w, d, 0, 1);

    // Reuse after reset must reload weights (8 handshakes)
    apply_reset();
    w = '{8'd9, 8'd8, 8'd7, 8'd6}; d = '{8'd2, 8'd3, 8'd4, 8'd5};
    run_op(1, w, d, 0, 0);

    // Randomised jobs with gaps and output backpressure
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 4; i++) begin w[i] = 8'($urandom); d[i] = 8'($urandom); end
      run_op(bit'($urandom_range(0, 1)), w, d, 1, (k == 0) ? 5 : $urandom_range(0, 5));
    end

    // Reset in the middle of LOAD_D after two data bytes
    do_cmd(0);
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1'b1, 0);
    m_wloaded = 1;
    send_byte(8'd3, 1'b0, 0);
    send_byte(8'd4, 1'b0, 0);
    apply_reset();
    w = '{8'd10, 8'd20, 8'd30, 8'd40}; d = '{8'd1, 8'd2, 8'd3, 8'd4};
    run_op(1, w, d, 1, 2);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
